trinity_genome_mutator: RTL
===========================

Name: trinity_genome_mutator

Overview:
Downstream consumer of the ternary gene sequencer's mutation_trit stream. It holds a genome of GENOME_LEN ternary weights in a register array. On start, it drives the sequencer's enable for one full pass and applies each returned mutation trit to the matching genome slot by saturating ternary addition. It also provides a host write port, a registered read port, and a count of the mutations applied.

Parameters:
GENOME_LEN, 16, number of trits in the genome (2..256)
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= GENOME_LEN

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
start  input  1  single-cycle request to begin a mutation pass
busy  output  1  high while a pass is in progress
done  output  1  single-cycle pulse when a pass completes
seq_enable  output  1  drives the sequencer enable input
mutation_trit  input  2  sequencer output: 00 Z, 01 P(+1), 10 N(-1), 11 treated as Z
wr_en  input  1  host write strobe
wr_addr  input  ADDR_W  host write address
wr_trit  input  2  host write data (same encoding)
rd_addr  input  ADDR_W  host read address
rd_trit  output  2  registered read data
mut_count  output  ADDR_W+1  nonzero mutations applied in the last pass

Behaviour:
- Reset (asynchronous, immediate, including mid-pass):
  - all genome slots = 00
  - state = IDLE
  - busy = 0, done = 0, seq_enable = 0
  - rd_trit = 00, mut_count = 0
  - internal counters = 0
- Encoding:
  - 11 from any source (host or sequencer) is treated as Z.
  - Stored value is always one of 00/01/10. A write of 11 stores 00.
- State IDLE:
  - busy = 0, seq_enable = 0.
  - start = 1 -> RUN on the next edge. mut_count and issue_idx are cleared on that edge.
- State RUN:
  - seq_enable = 1 while issue_idx < GENOME_LEN; issue_idx increments on each such cycle.
  - Sequencer latency is exactly one cycle. The trit sampled in cycle t+1 belongs to the enable issued in cycle t.
  - Apply happens in each cycle where apply_valid (a registered copy of the previous cycle's seq_enable) is 1:
    - slot[apply_idx] <= sat_add(slot[apply_idx], mutation_trit)
    - apply_idx increments
    - mut_count increments if the trit is P or N
  - sat_add rules:
    - Z+x = x
    - P+N = Z, N+P = Z
    - P+P = P, N+N = N (saturate)
    - x+Z = x
  - When the apply for index GENOME_LEN-1 occurs -> DONE.
  - seq_enable is high for exactly GENOME_LEN consecutive cycles, starting the cycle after start is accepted.
- State DONE:
  - done = 1 for one cycle, busy = 0, then IDLE.
  - Back-to-back: start asserted during DONE is ignored; start is accepted only in IDLE.
- busy = 1 only in RUN.
- Pass latency: start sampled at edge E0 -> done high in the cycle after edge E0+GENOME_LEN+1, i.e. GENOME_LEN+2 cycles from start.
- Host write:
  - Accepted only when state = IDLE or DONE; ignored while busy.
  - Out-of-range wr_addr (>= GENOME_LEN) is ignored.
  - If wr_en and start are asserted in the same IDLE cycle, the write takes effect before the pass begins.
- Host read:
  - rd_trit <= slot[rd_addr] every cycle, one-cycle latency, including during RUN. It shows the pre-update value of a slot being written in the same cycle.
  - Out-of-range rd_addr returns 00.
- start asserted while busy: ignored, no queuing.
- mut_count holds its value until the next accepted start.

Test Plan:
- Reset, then read all 16 slots -> rd_trit = 00 each; busy = 0, done = 0, seq_enable = 0, mut_count = 0.
- Write slot3 = 01, slot4 = 10, slot5 = 11; read 3/4/5 -> 01, 10, 00, each one cycle after rd_addr is presented.
- Stub sequencer (one-cycle registered response, all trits 00 except index 3 = 01 and index 4 = 01); start with the genome above:
  - seq_enable high exactly 16 cycles, done exactly GENOME_LEN+2 cycles after start
  - slot3 = 01 (saturated), slot4 = 00, mut_count = 2
- Stub returning 11 on every index -> genome unchanged, mut_count = 0. During the pass, wr_en with wr_addr=0, wr_trit=01 is ignored -> slot0 = 00 afterwards.
- start pulsed again on cycle 5 of RUN and during DONE -> only one pass runs; seq_enable total = 16.
- Assert rst_n low on cycle 8 of RUN -> busy, seq_enable and done = 0 immediately, all slots = 00, mut_count = 0. A new start afterwards completes a normal pass.

Source files
------------

// File: rtl/trinity_genome_mutator.sv
// Ternary genome store that runs one sequencer pass per start and folds each returned
// mutation trit into its slot by saturating ternary addition; host write/read ports.
module trinity_genome_mutator #(
  parameter int GENOME_LEN = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              seq_enable,
  input  logic [1:0]        mutation_trit,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_trit,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_trit,
  output logic [ADDR_W:0]   mut_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0]   LEN_W    = (ADDR_W+1)'(GENOME_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(GENOME_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   issue_idx_q, issue_idx_d;
  logic [ADDR_W-1:0] apply_idx_q, apply_idx_d;
  logic              apply_valid_q, apply_valid_d;
  logic              seq_enable_q, seq_enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        rd_trit_q, rd_trit_d;
  logic [ADDR_W:0]   mut_count_q, mut_count_d;
  logic [1:0]        genome_q [GENOME_LEN];
  logic [1:0]        genome_d [GENOME_LEN];

  // 11 is an unused code point and always collapses to Z.
  function automatic logic [1:0] norm(input logic [1:0] t);
    return (t == 2'b11) ? 2'b00 : t;
  endfunction

  function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] bn;
    bn = norm(b);
    if (bn == 2'b00)     return a;
    else if (a == 2'b00) return bn;
    else if (a == bn)    return a;
    else                 return 2'b00;
  endfunction

  always_comb begin
    state_d       = state_q;
    issue_idx_d   = issue_idx_q;
    apply_idx_d   = apply_idx_q;
    apply_valid_d = seq_enable_q;
    seq_enable_d  = 1'b0;
    done_d        = 1'b0;
    mut_count_d   = mut_count_q;
    genome_d      = genome_q;
    rd_trit_d     = ({1'b0, rd_addr} < LEN_W) ? genome_q[rd_addr] : 2'b00;

    case (state_q)
      IDLE, DONE: begin
        if (wr_en && ({1'b0, wr_addr} < LEN_W))
          genome_d[wr_addr] = norm(wr_trit);
        if (state_q == DONE) begin
          state_d = IDLE;
        end else if (start) begin
          state_d      = RUN;
          issue_idx_d  = '0;
          apply_idx_d  = '0;
          mut_count_d  = '0;
          seq_enable_d = 1'b1;
        end
      end
      RUN: begin
        if (seq_enable_q) begin
          issue_idx_d  = issue_idx_q + (ADDR_W+1)'(1);
          seq_enable_d = (issue_idx_q + (ADDR_W+1)'(1)) < LEN_W;
        end
        // The trit on the port now answers the enable issued one cycle ago.
        if (apply_valid_q) begin
          genome_d[apply_idx_q] = sat_add(genome_q[apply_idx_q], mutation_trit);
          apply_idx_d = apply_idx_q + ADDR_W'(1);
          if (norm(mutation_trit) != 2'b00)
            mut_count_d = mut_count_q + (ADDR_W+1)'(1);
          if (apply_idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      issue_idx_q   <= '0;
      apply_idx_q   <= '0;
      apply_valid_q <= 1'b0;
      seq_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_trit_q     <= 2'b00;
      mut_count_q   <= '0;
      genome_q      <= '{default: 2'b00};
    end else begin
      state_q       <= state_d;
      issue_idx_q   <= issue_idx_d;
      apply_idx_q   <= apply_idx_d;
      apply_valid_q <= apply_valid_d;
      seq_enable_q  <= seq_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_trit_q     <= rd_trit_d;
      mut_count_q   <= mut_count_d;
      genome_q      <= genome_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign seq_enable = seq_enable_q;
  assign rd_trit    = rd_trit_q;
  assign mut_count  = mut_count_q;

endmodule
